// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EX and EX/MEM pipeline registers driven by the hazard unit's
// stall/flush controls, plus saturating stall and flush event counters.
module pipe_stage_regs #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CTRL_W   = 10,
    parameter int          MCTRL_W  = 5,
    parameter int          CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        pc_next_i,
    input  logic               pc_write_i,
    input  logic               pc_src_i,
    output logic [31:0]        pc_o,
    input  logic [31:0]        if_instr_i,
    input  logic [31:0]        if_pc4_i,
    input  logic               if_id_write_i,
    input  logic               if_flush_i,
    output logic [31:0]        id_instr_o,
    output logic [31:0]        id_pc4_o,
    output logic               id_valid_o,
    input  logic [CTRL_W-1:0]  id_ctrl_i,
    input  logic [4:0]         id_rs_i,
    input  logic [4:0]         id_rt_i,
    input  logic [4:0]         id_rd_i,
    input  logic               id_flush_i,
    output logic [CTRL_W-1:0]  ex_ctrl_o,
    output logic [4:0]         ex_rs_o,
    output logic [4:0]         ex_rt_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_valid_o,
    input  logic [MCTRL_W-1:0] ex_mctrl_i,
    input  logic               ex_flush_i,
    output logic [MCTRL_W-1:0] mem_ctrl_o,
    output logic               mem_valid_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    logic [31:0]        pc_reg;
    logic [31:0]        id_instr_reg;
    logic [31:0]        id_pc4_reg;
    logic               id_valid_reg;
    logic [CTRL_W-1:0]  ex_ctrl_reg;
    logic [4:0]         ex_rs_reg;
    logic [4:0]         ex_rt_reg;
    logic [4:0]         ex_rd_reg;
    logic               ex_valid_reg;
    logic [MCTRL_W-1:0] mem_ctrl_reg;
    logic               mem_valid_reg;

    // A redirect must win over a load-use hold, so either enable loads the PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_reg <= RESET_PC;
        end else if (pc_write_i || pc_src_i) begin
            pc_reg <= pc_next_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || if_flush_i) begin
            id_instr_reg <= 32'd0;
            id_pc4_reg   <= 32'd0;
            id_valid_reg <= 1'b0;
        end else if (if_id_write_i) begin
            id_instr_reg <= if_instr_i;
            id_pc4_reg   <= if_pc4_i;
            id_valid_reg <= 1'b1;
        end
    end

    // ID/EX has no hold path: a stall reaches it as a bubble through id_flush_i.
    always_ff @(posedge clk_i) begin
        if (rst_i || id_flush_i) begin
            ex_ctrl_reg  <= '0;
            ex_rs_reg    <= 5'd0;
            ex_rt_reg    <= 5'd0;
            ex_rd_reg    <= 5'd0;
            ex_valid_reg <= 1'b0;
        end else begin
            ex_ctrl_reg  <= id_ctrl_i;
            ex_rs_reg    <= id_rs_i;
            ex_rt_reg    <= id_rt_i;
            ex_rd_reg    <= id_rd_i;
            ex_valid_reg <= id_valid_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || ex_flush_i) begin
            mem_ctrl_reg  <= '0;
            mem_valid_reg <= 1'b0;
        end else begin
            mem_ctrl_reg  <= ex_mctrl_i;
            mem_valid_reg <= ex_valid_reg;
        end
    end

    // Event counters: index 0 counts stall cycles, index 1 counts IF flushes.
    logic [1:0]       cnt_evt;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_evt[0] = !pc_write_i && !pc_src_i;
    assign cnt_evt[1] = if_flush_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign pc_o        = pc_reg;
    assign id_instr_o  = id_instr_reg;
    assign id_pc4_o    = id_pc4_reg;
    assign id_valid_o  = id_valid_reg;
    assign ex_ctrl_o   = ex_ctrl_reg;
    assign ex_rs_o     = ex_rs_reg;
    assign ex_rt_o     = ex_rt_reg;
    assign ex_rd_o     = ex_rd_reg;
    assign ex_valid_o  = ex_valid_reg;
    assign mem_ctrl_o  = mem_ctrl_reg;
    assign mem_valid_o = mem_valid_reg;
    assign stall_cnt_o = cnt_reg[0];
    assign flush_cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: a table of cycle vectors with hand-derived expected
// register contents, queued at drive time and compared one edge later.
module tb_pipe_stage_regs;

    localparam int CNT_W = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_next_i;
    logic        pc_write_i;
    logic        pc_src_i;
    logic [31:0] pc_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc4_i;
    logic        if_id_write_i;
    logic        if_flush_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc4_o;
    logic        id_valid_o;
    logic [9:0]  id_ctrl_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
    logic        id_flush_i;
    logic [9:0]  ex_ctrl_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic        ex_valid_o;
    logic [4:0]  ex_mctrl_i;
    logic        ex_flush_i;
    logic [4:0]  mem_ctrl_o;
    logic        mem_valid_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_stage_regs #(
        .RESET_PC(32'd0),
        .CTRL_W  (10),
        .MCTRL_W (5),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_next_i    (pc_next_i),
        .pc_write_i   (pc_write_i),
        .pc_src_i     (pc_src_i),
        .pc_o         (pc_o),
        .if_instr_i   (if_instr_i),
        .if_pc4_i     (if_pc4_i),
        .if_id_write_i(if_id_write_i),
        .if_flush_i   (if_flush_i),
        .id_instr_o   (id_instr_o),
        .id_pc4_o     (id_pc4_o),
        .id_valid_o   (id_valid_o),
        .id_ctrl_i    (id_ctrl_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rd_i      (id_rd_i),
        .id_flush_i   (id_flush_i),
        .ex_ctrl_o    (ex_ctrl_o),
        .ex_rs_o      (ex_rs_o),
        .ex_rt_o      (ex_rt_o),
        .ex_rd_o      (ex_rd_o),
        .ex_valid_o   (ex_valid_o),
        .ex_mctrl_i   (ex_mctrl_i),
        .ex_flush_i   (ex_flush_i),
        .mem_ctrl_o   (mem_ctrl_o),
        .mem_valid_o  (mem_valid_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc_next;
        logic        pc_write;
        logic        pc_src;
        logic [31:0] if_instr;
        logic [31:0] if_pc4;
        logic        if_id_write;
        logic        if_flush;
        logic [9:0]  id_ctrl;
        logic [14:0] regs;
        logic        id_flush;
        logic [4:0]  ex_mctrl;
        logic        ex_flush;
    } in_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_instr;
        logic [31:0] id_pc4;
        logic        id_valid;
        logic [9:0]  ex_ctrl;
        logic [14:0] ex_regs;
        logic        ex_valid;
        logic [4:0]  mem_ctrl;
        logic        mem_valid;
        logic [3:0]  stall;
        logic [3:0]  flush;
    } exp_t;

    typedef struct {
        in_t  stim;
        exp_t want;
    } vec_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [7:0]  cnt_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [14:0] regs3(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c);
        return {a, b, c};
    endfunction

    task automatic add(input in_t s, input exp_t w);
        vec_t v;
        v.stim = s;
        v.want = w;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t s);
        rst_i         = s.rst;
        pc_next_i     = s.pc_next;
        pc_write_i    = s.pc_write;
        pc_src_i      = s.pc_src;
        if_instr_i    = s.if_instr;
        if_pc4_i      = s.if_pc4;
        if_id_write_i = s.if_id_write;
        if_flush_i    = s.if_flush;
        id_ctrl_i     = s.id_ctrl;
        {id_rs_i, id_rt_i, id_rd_i} = s.regs;
        id_flush_i    = s.id_flush;
        ex_mctrl_i    = s.ex_mctrl;
        ex_flush_i    = s.ex_flush;
    endtask

    task automatic chk(input int idx, input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL step %0d %s: got %h required %h", idx, nm, act, want);
        end
    endtask

    task automatic check_all(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step %0d scoreboard: got empty queue required an entry", idx);
            return;
        end
        e = exp_q.pop_front();
        chk(idx, "pc_o",        pc_o,                          e.pc);
        chk(idx, "id_instr_o",  id_instr_o,                    e.id_instr);
        chk(idx, "id_pc4_o",    id_pc4_o,                      e.id_pc4);
        chk(idx, "id_valid_o",  32'(id_valid_o),               32'(e.id_valid));
        chk(idx, "ex_ctrl_o",   32'(ex_ctrl_o),                32'(e.ex_ctrl));
        chk(idx, "ex_regs",     32'({ex_rs_o, ex_rt_o, ex_rd_o}), 32'(e.ex_regs));
        chk(idx, "ex_valid_o",  32'(ex_valid_o),               32'(e.ex_valid));
        chk(idx, "mem_ctrl_o",  32'(mem_ctrl_o),               32'(e.mem_ctrl));
        chk(idx, "mem_valid_o", 32'(mem_valid_o),              32'(e.mem_valid));
        chk(idx, "stall_cnt_o", 32'(stall_cnt_o),              32'(e.stall));
        chk(idx, "flush_cnt_o", 32'(flush_cnt_o),              32'(e.flush));
        $display("step %0d: pc=%h id_instr=%h idv=%b exv=%b memv=%b stall=%0d flush=%0d",
                 idx, pc_o, id_instr_o, id_valid_o, ex_valid_o, mem_valid_o,
                 stall_cnt_o, flush_cnt_o);
    endtask

    task automatic check_cnt(input int idx);
        logic [7:0] c;
        if (cnt_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sat %0d scoreboard: got empty queue required an entry", idx);
            return;
        end
        c = cnt_q.pop_front();
        chk(idx, "sat stall_cnt_o", 32'(stall_cnt_o), 32'(c[7:4]));
        chk(idx, "sat flush_cnt_o", 32'(flush_cnt_o), 32'(c[3:0]));
        $display("sat %0d: stall=%0d flush=%0d", idx, stall_cnt_o, flush_cnt_o);
    endtask

    initial begin
        in_t  s_idle;
        in_t  s_sat;
        exp_t zero;

        zero   = '{32'h0, 32'h0, 32'h0, 1'b0, 10'h0, 15'h0, 1'b0, 5'h0, 1'b0, 4'h0, 4'h0};
        s_idle = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'h0, 15'h1234,
                   1'b0, 5'h0, 1'b0};

        // Reset held two edges while PCWrite tries to load 0x40.
        add(s_idle, zero);
        add(s_idle, zero);
        // Sequential fetch.
        add('{1'b0, 32'h40, 1'b1, 1'b0, 32'h8C220004, 32'h4, 1'b1, 1'b0, 10'h155,
              regs3(5'd1, 5'd2, 5'd3), 1'b0, 5'h0A, 1'b0},
            '{32'h40, 32'h8C220004, 32'h4, 1'b1, 10'h155, regs3(5'd1, 5'd2, 5'd3),
              1'b0, 5'h0A, 1'b0, 4'd0, 4'd0});
        add('{1'b0, 32'h44, 1'b1, 1'b0, 32'h00221820, 32'h8, 1'b1, 1'b0, 10'h2AA,
              regs3(5'd4, 5'd5, 5'd6), 1'b0, 5'h15, 1'b0},
            '{32'h44, 32'h00221820, 32'h8, 1'b1, 10'h2AA, regs3(5'd4, 5'd5, 5'd6),
              1'b1, 5'h15, 1'b0, 4'd0, 4'd0});
        // Load-use stall: PC and IF/ID hold, bubble into ID/EX.
        add('{1'b0, 32'h48, 1'b0, 1'b0, 32'hDEADBEEF, 32'hC, 1'b0, 1'b0, 10'h3FF,
              regs3(5'd7, 5'd8, 5'd9), 1'b1, 5'h1F, 1'b0},
            '{32'h44, 32'h00221820, 32'h8, 1'b1, 10'h0, 15'h0,
              1'b0, 5'h1F, 1'b1, 4'd1, 4'd0});
        add('{1'b0, 32'h48, 1'b1, 1'b0, 32'h12345678, 32'h48, 1'b1, 1'b0, 10'h001,
              regs3(5'd10, 5'd11, 5'd12), 1'b0, 5'h01, 1'b0},
            '{32'h48, 32'h12345678, 32'h48, 1'b1, 10'h001, regs3(5'd10, 5'd11, 5'd12),
              1'b1, 5'h01, 1'b0, 4'd1, 4'd0});
        // Branch flush of all three stages.
        add('{1'b0, 32'h100, 1'b1, 1'b1, 32'hAAAAAAAA, 32'h4C, 1'b1, 1'b1, 10'h0F0,
              regs3(5'd13, 5'd14, 5'd15), 1'b1, 5'h0C, 1'b1},
            '{32'h100, 32'h0, 32'h0, 1'b0, 10'h0, 15'h0, 1'b0, 5'h0, 1'b0, 4'd1, 4'd1});
        add('{1'b0, 32'h104, 1'b1, 1'b0, 32'h20080005, 32'h104, 1'b1, 1'b0, 10'h111,
              regs3(5'd16, 5'd17, 5'd18), 1'b0, 5'h03, 1'b0},
            '{32'h104, 32'h20080005, 32'h104, 1'b1, 10'h111, regs3(5'd16, 5'd17, 5'd18),
              1'b0, 5'h03, 1'b0, 4'd1, 4'd1});
        // Stall and branch together: redirect loads PC, flush beats hold.
        add('{1'b0, 32'h200, 1'b0, 1'b1, 32'h55555555, 32'h108, 1'b0, 1'b1, 10'h222,
              regs3(5'd19, 5'd20, 5'd21), 1'b0, 5'h06, 1'b0},
            '{32'h200, 32'h0, 32'h0, 1'b0, 10'h222, regs3(5'd19, 5'd20, 5'd21),
              1'b1, 5'h06, 1'b0, 4'd1, 4'd2});
        add('{1'b0, 32'h300, 1'b0, 1'b0, 32'h66666666, 32'h204, 1'b0, 1'b0, 10'h033,
              regs3(5'd22, 5'd23, 5'd24), 1'b0, 5'h11, 1'b0},
            '{32'h200, 32'h0, 32'h0, 1'b0, 10'h033, regs3(5'd22, 5'd23, 5'd24),
              1'b0, 5'h11, 1'b1, 4'd2, 4'd2});
        // Reset mid-stall and mid-flush.
        add('{1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 10'h3FF,
              regs3(5'd25, 5'd26, 5'd27), 1'b0, 5'h1F, 1'b0}, zero);
        add('{1'b0, 32'h500, 1'b0, 1'b0, 32'h77777777, 32'h10, 1'b1, 1'b0, 10'h044,
              regs3(5'd28, 5'd29, 5'd30), 1'b0, 5'h02, 1'b0},
            '{32'h0, 32'h77777777, 32'h10, 1'b1, 10'h044, regs3(5'd28, 5'd29, 5'd30),
              1'b0, 5'h02, 1'b0, 4'd1, 4'd0});

        foreach (vecs[i]) begin
            drive(vecs[i].stim);
            exp_q.push_back(vecs[i].want);
            @(posedge clk_i);
            #1;
            check_all(i);
        end

        // Saturation: reset, then 20 cycles that are both stall and flush cycles.
        drive(s_idle);
        cnt_q.push_back(8'h00);
        @(posedge clk_i);
        #1;
        check_cnt(0);
        s_sat = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 10'h0, 15'h0,
                  1'b0, 5'h0, 1'b0};
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] sat;
            sat = (k > 15) ? 4'hF : 4'(k);
            drive(s_sat);
            cnt_q.push_back({sat, sat});
            @(posedge clk_i);
            #1;
            check_cnt(k);
        end
        drive(s_idle);
        cnt_q.push_back(8'h00);
        @(posedge clk_i);
        #1;
        check_cnt(21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
